// File: rtl/result_monitor.sv
// result_monitor: self-check monitor on the CPU data-memory write bus.
// It waits for the begin symbol on the test port. It then compares each
// accepted test-port write against exp_data, a table looked up through
// exp_idx. It counts mismatches and the cycles spent checking, and it
// reports finish/pass at the end of the run.
// Optional feature: define RESULT_MONITOR_FIRST_ERR_EN to add first-mismatch
// capture outputs (first_err_idx/got/exp/vld).
//
//   state  | meaning
//   IDLE   | waiting for the begin symbol on the test port
//   CHECK  | comparing test-port writes, counting cycles
//   REPORT | run over, results frozen until reset
module result_monitor #(
  parameter int              AW        = 30,
  parameter int              DW        = 32,
  parameter int              EW        = 8,
  parameter int              CW        = 16,
  parameter int              IW        = 7,
  parameter logic [AW-1:0]   TEST_PORT = 30'hFF,
  parameter logic [DW-1:0]   BEGIN_SYM = 32'h00000168,
  parameter int              CHECK_NUM = 95,
  parameter bit              SWAP_EN   = 1'b1,
  parameter int              TIMEOUT   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          wen,
  output logic [IW-1:0] exp_idx,
  input  logic [DW-1:0] exp_data,
  output logic [EW-1:0] error_num,
  output logic [CW-1:0] duration,
  output logic          finish,
  output logic          pass,
  output logic          timeout
`ifdef RESULT_MONITOR_FIRST_ERR_EN
  ,
  output logic [IW-1:0] first_err_idx,
  output logic [DW-1:0] first_err_got,
  output logic [DW-1:0] first_err_exp,
  output logic          first_err_vld
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_END = IW'(CHECK_NUM);

  state_t        state_q;
  logic          armed_q;
  logic [IW-1:0] exp_idx_q;
  logic [EW-1:0] error_num_q;
  logic [CW-1:0] duration_q;
  logic          finish_q;
  logic          pass_q;
  logic          timeout_q;
  logic [EW-1:0] error_num_d;
  logic [CW-1:0] duration_d;

`ifdef RESULT_MONITOR_FIRST_ERR_EN
  logic [IW-1:0] first_err_idx_q;
  logic [DW-1:0] first_err_got_q;
  logic [DW-1:0] first_err_exp_q;
  logic          first_err_vld_q;
`endif

  logic [DW-1:0] dm;
  logic          port_hit;
  logic          accept;
  logic          begin_hit;
  logic          mismatch;
  logic          to_hit;
  logic          done;

  // Byte-order adjustment of the bus data before any comparison
  always_comb begin
    dm = data;
    if (SWAP_EN) begin
      for (int b = 0; b < DW/8; b++) begin
        dm[8*b +: 8] = data[DW-8-8*b +: 8];
      end
    end
  end

  // A write is accepted only on the first cycle of a wen burst, so a write
  // stalled by the D-cache is counted once.
  assign port_hit  = (addr == TEST_PORT) && wen;
  assign accept    = port_hit && armed_q;
  assign begin_hit = port_hit && (dm == BEGIN_SYM);
  assign mismatch  = (dm != exp_data);
  assign to_hit    = (TIMEOUT != 0) && (duration_q == TO_LAST);
  assign done      = (exp_idx_q == IDX_END);

  // Saturating next values of the two counters
  always_comb begin
    error_num_d = (error_num_q == '1) ? error_num_q : error_num_q + 1'b1;
    duration_d  = (duration_q == '1) ? duration_q : duration_q + 1'b1;
  end

  // Monitor FSM with its counters and registered result flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      exp_idx_q   <= '0;
      error_num_q <= '1;
      duration_q  <= '0;
      finish_q    <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef RESULT_MONITOR_FIRST_ERR_EN
      first_err_idx_q <= '0;
      first_err_got_q <= '0;
      first_err_exp_q <= '0;
      first_err_vld_q <= 1'b0;
`endif
    end else begin
      armed_q <= ~wen;
      case (state_q)
        IDLE: begin
          if (begin_hit) begin
            state_q     <= CHECK;
            error_num_q <= '0;
            duration_q  <= '0;
            exp_idx_q   <= '0;
          end
        end
        CHECK: begin
          if (to_hit) begin
            // Timeout wins over a write arriving in the same cycle.
            state_q   <= REPORT;
            finish_q  <= 1'b1;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end else if (done) begin
            state_q    <= REPORT;
            finish_q   <= 1'b1;
            pass_q     <= (error_num_q == '0);
            duration_q <= duration_d;
          end else begin
            duration_q <= duration_d;
            if (accept) begin
              exp_idx_q <= exp_idx_q + 1'b1;
              if (mismatch) begin
                error_num_q <= error_num_d;
`ifdef RESULT_MONITOR_FIRST_ERR_EN
                if (!first_err_vld_q) begin
                  first_err_idx_q <= exp_idx_q;
                  first_err_got_q <= dm;
                  first_err_exp_q <= exp_data;
                  first_err_vld_q <= 1'b1;
                end
`endif
              end
            end
          end
        end
        REPORT: begin
          state_q <= REPORT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign exp_idx   = exp_idx_q;
  assign error_num = error_num_q;
  assign duration  = duration_q;
  assign finish    = finish_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;

`ifdef RESULT_MONITOR_FIRST_ERR_EN
  assign first_err_idx = first_err_idx_q;
  assign first_err_got = first_err_got_q;
  assign first_err_exp = first_err_exp_q;
  assign first_err_vld = first_err_vld_q;
`endif

endmodule
